// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//
// Purpose:
//   Owns the fetch PC register of the IF stage. It resolves the conditional
//   branches and jumps presented by decode and steers the PC toward them.
//   While the pipeline is stalled, a redirect is parked in a target latch and
//   applied once the stall clears. An exception request overrides everything
//   and sends fetch to EXC_VEC. With DELAY_SLOT=0 the wrong-path instruction
//   already fetched into IF/ID is killed through flush_if.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   stall              hold the PC (hazard or memory wait)
//   exc_req            redirect to EXC_VEC, overrides stall
//   dec_pc             PC of the instruction in decode
//   br_valid, br_type  conditional branch present and its comparison code
//   rs_data, rt_data   forwarded operands for the branch compare
//   imm16              branch offset in words
//   jmp_valid, jmp_reg jump present; 0 = j/jal, 1 = jr/jalr
//   instr_index        j/jal index field
//   jr_addr            register jump target
//   pc                 registered fetch PC
//   pc_plus4           pc + 4 (combinational)
//   flush_if           kill the IF/ID instruction (combinational)
//   redirect_pending   a latched target is waiting for the stall to clear
//   misalign_err       one-cycle pulse for a jr target with nonzero low bits
// ---------------------------------------------------------------------------
module pc_next_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] dec_pc,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  input  logic [15:0]       imm16,
  input  logic              jmp_valid,
  input  logic              jmp_reg,
  input  logic [25:0]       instr_index,
  input  logic [31:0]       jr_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              flush_if,
  output logic              redirect_pending,
  output logic              misalign_err
);

  typedef enum logic {RUN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                misalign_q, misalign_d;

  logic                taken;
  logic                redirect;
  logic [ADDR_W-1:0]   dec_plus4;
  logic [31:0]         dec_plus4_ext;
  logic [31:0]         br_off32;
  logic [31:0]         j_tgt32;
  logic [ADDR_W-1:0]   br_tgt;
  logic [ADDR_W-1:0]   j_tgt;
  logic [ADDR_W-1:0]   jr_tgt;
  logic [ADDR_W-1:0]   redir_tgt;

  // Branch condition and target computation. Comparisons are signed on the
  // full 32-bit operands. The j/jal target is assembled at 32 bits and then
  // truncated, so narrow PCs simply drop the region bits they cannot hold.
  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      3'b001:  taken = (rs_data == rt_data);
      3'b010:  taken = (rs_data != rt_data);
      3'b011:  taken = ($signed(rs_data) >  32'sd0);
      3'b100:  taken = ($signed(rs_data) <= 32'sd0);
      3'b101:  taken = ($signed(rs_data) <  32'sd0);
      3'b110:  taken = ($signed(rs_data) >= 32'sd0);
      default: taken = 1'b0;
    endcase

    dec_plus4     = dec_pc + ADDR_W'(4);
    dec_plus4_ext = 32'(dec_plus4);
    br_off32      = {{14{imm16[15]}}, imm16, 2'b00};
    br_tgt        = dec_plus4 + br_off32[ADDR_W-1:0];
    j_tgt32       = {dec_plus4_ext[31:28], instr_index, 2'b00};
    j_tgt         = j_tgt32[ADDR_W-1:0];
    jr_tgt        = {jr_addr[ADDR_W-1:2], 2'b00};

    redirect  = jmp_valid | (br_valid & taken);
    // A jump beats a simultaneous branch.
    if (jmp_valid) begin
      redir_tgt = jmp_reg ? jr_tgt : j_tgt;
    end else begin
      redir_tgt = br_tgt;
    end
  end

  // Next PC, target latch and RUN/HOLD state, in priority order. The
  // misalignment pulse is raised only when the jr is actually accepted
  // (not stalled, not overridden by an exception), so a stalled jr does not
  // report the same fault on every held cycle.
  always_comb begin
    pc_d       = pc_q + ADDR_W'(4);
    tgt_d      = tgt_q;
    state_d    = state_q;
    misalign_d = jmp_valid & jmp_reg & (|jr_addr[1:0]) & ~stall & ~exc_req;

    if (exc_req) begin
      pc_d    = EXC_VEC[ADDR_W-1:0];
      tgt_d   = '0;
      state_d = RUN;
    end else if (stall && redirect) begin
      pc_d    = pc_q;
      tgt_d   = redir_tgt;
      state_d = HOLD;
    end else if (stall) begin
      pc_d    = pc_q;
    end else if (state_q == HOLD) begin
      pc_d    = redirect ? redir_tgt : tgt_q;
      state_d = RUN;
    end else if (redirect) begin
      pc_d    = redir_tgt;
    end
  end

  // State registers; reset discards any pending target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC[ADDR_W-1:0];
      tgt_q      <= '0;
      state_q    <= RUN;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  // Output drive. Without a delay slot, whatever IF fetched behind a taken
  // redirect (new or released from HOLD) is on the wrong path.
  always_comb begin
    pc               = pc_q;
    pc_plus4         = pc_q + ADDR_W'(4);
    redirect_pending = (state_q == HOLD);
    misalign_err     = misalign_q;
    flush_if         = (DELAY_SLOT == 1'b0) & ~stall & ~exc_req &
                       (redirect | (state_q == HOLD));
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the combinational next-PC selector.
- Owns the fetch PC register and resolves branches and jumps presented by the decode stage.
- Handles stalls by holding a pending redirect until the stall clears.
- Supports optional branch-delay-slot semantics and an exception vector override.
- Sits in the IF stage of the pipelined core and drives the instruction-memory address.

Parameters:
- ADDR_W, 32, PC width; legal range 28..32.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, PC value loaded on exception request.
- DELAY_SLOT, 1, 1 = MIPS delay slot is executed; 0 = the wrong-path IF instruction is flushed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (hazard or memory wait).
- exc_req  in  1  exception/interrupt redirect to EXC_VEC.
- dec_pc  in  ADDR_W  PC of the instruction currently in decode.
- br_valid  in  1  decode holds a conditional branch.
- br_type  in  3  001 beq, 010 bne, 011 bgtz, 100 blez, 101 bltz, 110 bgez; all other codes never taken.
- rs_data  in  32  forwarded rs operand.
- rt_data  in  32  forwarded rt operand.
- imm16  in  16  branch offset, in words.
- jmp_valid  in  1  decode holds a jump.
- jmp_reg  in  1  0 = j/jal (instr_index), 1 = jr/jalr (jr_addr).
- instr_index  in  26  jump index field.
- jr_addr  in  32  register jump target.
- pc  out  ADDR_W  current fetch PC (registered).
- pc_plus4  out  ADDR_W  pc+4 (combinational).
- flush_if  out  1  kill the IF/ID instruction (combinational).
- redirect_pending  out  1  latched target is waiting for the stall to clear (registered).
- misalign_err  out  1  one-cycle pulse: jr target low bits were nonzero (registered).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC[ADDR_W-1:0]
  - state = RUN, latched target = 0
  - redirect_pending = 0, misalign_err = 0
- Branch decision (combinational, signed 32-bit compares):
  - beq: rs==rt
  - bne: rs!=rt
  - bgtz: rs>0
  - blez: rs<=0
  - bltz: rs<0
  - bgez: rs>=0
- Targets (all sums truncated to ADDR_W, wrap modulo 2^ADDR_W):
  - Branch: dec_pc+4 + (sext(imm16)<<2).
  - j/jal: {(dec_pc+4)[ADDR_W-1:28], instr_index, 2'b00}.
  - jr: {jr_addr[ADDR_W-1:2], 2'b00}; if jr_addr[1:0]!=0, misalign_err=1 in the next cycle only.
- Redirect request:
  - redirect = (jmp_valid) | (br_valid & taken).
  - If jmp_valid and br_valid are both high, the jump wins.
- Per-edge priority, highest first:
  1. exc_req: pc<=EXC_VEC, state<=RUN, pending cleared; stall is ignored.
  2. stall & redirect: pc held, target latched, state<=HOLD. If a redirect arrives again while in HOLD, the latest target overwrites the latch.
  3. stall, no redirect: pc held, state unchanged.
  4. state HOLD & !stall: pc<=latched target, state<=RUN. A redirect presented in this same cycle takes precedence over the latched target.
  5. redirect: pc<=target.
  6. Otherwise: pc<=pc+4, which wraps at 2^ADDR_W.
- FSM states:
  - RUN and HOLD.
  - redirect_pending = (state==HOLD).
- Latency: a redirect presented in cycle N appears on pc after edge N (one cycle).
- flush_if:
  - Always 0 when DELAY_SLOT=1.
  - When DELAY_SLOT=0: flush_if = !stall & !exc_req & (redirect | state==HOLD).
  - Exception flushing is the hazard unit's responsibility.
- Reset mid-HOLD: the pending target is discarded.

Test Plan:
1. Assert reset asynchronously between edges → pc=0x3000 immediately; release reset → pc steps 0x3004, 0x3008; pc_plus4 tracks pc+4.
2. dec_pc=0x3010, imm16=0x0002, rs=rt=5:
   - beq → pc=0x301C next edge.
   - bne with the same operands → pc=prev+4.
   - imm16=0xFFFE → pc=0x300C.
3. Signed branches:
   - rs=0x8000_0000: bgtz not taken; bltz taken to 0x301C.
   - rs=0: blez taken, bgez taken, bgtz not taken.
4. Jumps:
   - dec_pc=0x3020, instr_index=0x00000A, jmp_valid → pc=0x0000_0028.
   - jmp_reg=1, jr_addr=0x8765_4321 → pc=0x8765_4320, misalign_err high for exactly one cycle.
5. Stall with pending redirect:
   - stall=1 for 3 cycles with a taken beq (target 0x301C) → pc frozen, redirect_pending=1.
   - stall drops → pc=0x301C next edge, pending=0.
   - Repeat with exc_req pulsed during HOLD → pc=0x4180, pending cleared.
6. DELAY_SLOT=0 instance:
   - Taken beq → flush_if=1 in the same cycle and pc=target next edge.
   - Not-taken branch → flush_if=0.
   - Same instance with DELAY_SLOT=1 → flush_if never asserts.
